// File: rtl/song_sequencer.sv
// Beat-rate note sequencer: walks the song ROM one entry per beat, issuing a
// qualified lane mask per beat, with start/pause/stop control and note scoring.
module song_sequencer #(
  parameter int unsigned BEAT_DIV = 12_500_000,
  parameter int unsigned SONG_LEN = 94
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  output logic [6:0] rom_addr,
  input  logic [4:0] rom_data,
  output logic [4:0] note,
  output logic       note_valid,
  output logic [6:0] beat_idx,
  output logic [6:0] note_count,
  output logic       playing,
  output logic       done
);

  localparam int unsigned DIV_W  = 24;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned LANE_W = 5;
  localparam int unsigned CNT_W  = 7;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BEAT_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PLAYING = 2'd1;
  localparam logic [1:0] S_PAUSED  = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LANE_W-1:0] note_q, note_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              playing_q, playing_d;
  logic              done_q, done_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      addr_q    <= '0;
      note_q    <= '0;
      valid_q   <= 1'b0;
      beat_q    <= '0;
      count_q   <= '0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      addr_q    <= addr_d;
      note_q    <= note_d;
      valid_q   <= valid_d;
      beat_q    <= beat_d;
      count_q   <= count_d;
      playing_q <= playing_d;
      done_q    <= done_d;
    end
  end

  // Control priority: stop, start, pause, beat tick. The divider runs on the
  // pause level, so the first unpaused cycle after a pause already counts.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    addr_d  = addr_q;
    note_d  = note_q;
    valid_d = 1'b0;
    beat_d  = beat_q;
    count_d = count_q;

    if (stop) begin
      state_d = S_IDLE;
      addr_d  = '0;
      div_d   = '0;
    end else if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
      state_d = S_PLAYING;
      addr_d  = '0;
      div_d   = '0;
      count_d = '0;
    end else if (state_q == S_PLAYING || state_q == S_PAUSED) begin
      if (pause) begin
        state_d = S_PAUSED;
      end else begin
        state_d = S_PLAYING;
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          note_d  = rom_data;
          beat_d  = addr_q;
          valid_d = 1'b1;
          if (rom_data != '0 && count_q != CNT_MAX) begin
            count_d = count_q + CNT_W'(1);
          end
          if (addr_q == ADDR_LAST) begin
            state_d = S_DONE;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
    end

    playing_d = (state_d == S_PLAYING) || (state_d == S_PAUSED);
    done_d    = (state_d == S_DONE);
  end

  assign rom_addr   = addr_q;
  assign note       = note_q;
  assign note_valid = valid_q;
  assign beat_idx   = beat_q;
  assign note_count = count_q;
  assign playing    = playing_q;
  assign done       = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with BEAT_DIV=4, SONG_LEN=6 and a
// one-cycle-latency behavioural note ROM.
module tb_song_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       pause;
  logic       stop;
  logic [6:0] rom_addr;
  logic [4:0] rom_data;
  logic [4:0] note;
  logic       note_valid;
  logic [6:0] beat_idx;
  logic [6:0] note_count;
  logic       playing;
  logic       done;

  int n_pass  = 0;
  int n_total = 0;

  logic [4:0] song [6] = '{5'h01, 5'h00, 5'h04, 5'h10, 5'h08, 5'h02};
  logic [6:0] cnt_after [6] = '{7'd1, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5};
  logic [4:0] rom_mem [128];

  song_sequencer #(.BEAT_DIV(4), .SONG_LEN(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pause      (pause),
    .stop       (stop),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .note       (note),
    .note_valid (note_valid),
    .beat_idx   (beat_idx),
    .note_count (note_count),
    .playing    (playing),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 128; i++) rom_mem[i] = 5'h00;
    for (int i = 0; i < 6; i++) rom_mem[i] = song[i];
  end

  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  typedef struct {
    logic       rst_n, start, pause, stop;
    logic       valid;
    logic [4:0] note;
    logic [6:0] idx;
    logic [6:0] count;
    logic [6:0] addr;
    logic       playing, done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic s, logic p, logic t, logic v,
                              logic [4:0] n, logic [6:0] i, logic [6:0] c,
                              logic [6:0] a, logic pl, logic d);
    vec_t x;
    x.rst_n = r; x.start = s; x.pause = p; x.stop = t; x.valid = v;
    x.note = n; x.idx = i; x.count = c; x.addr = a; x.playing = pl; x.done = d;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step(input logic r, input logic s, input logic p, input logic t);
    rst_n = r; start = s; pause = p; stop = t;
    @(posedge clk);
    #1;
    rst_n = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0;
  endtask

  initial begin
    logic [4:0] pn;
    logic [6:0] pi;
    logic [6:0] pc;
    logic       p;
    rst_n = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;

    // Full song: reset, start, six beats of 3 quiet cycles + tick, DONE, restart.
    vecs.push_back(mk(0, 0, 0, 0, 0, 5'h00, 7'd0, 7'd0, 7'd0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 5'h00, 7'd0, 7'd0, 7'd0, 1, 0));
    pn = 5'h00; pi = 7'd0; pc = 7'd0;
    for (int b = 0; b < 6; b++) begin
      for (int q = 0; q < 3; q++)
        vecs.push_back(mk(1, 0, 0, 0, 0, pn, pi, pc, 7'(b), 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 1, song[b], 7'(b), cnt_after[b],
                        (b == 5) ? 7'd0 : 7'(b + 1), b != 5, b == 5));
      pn = song[b]; pi = 7'(b); pc = cnt_after[b];
    end
    vecs.push_back(mk(1, 0, 0, 0, 0, 5'h02, 7'd5, 7'd5, 7'd0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 5'h02, 7'd5, 7'd5, 7'd0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 5'h02, 7'd5, 7'd0, 7'd0, 1, 0));

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].start, vecs[i].pause, vecs[i].stop);
      chk($sformatf("v%0d_valid", i), 32'(note_valid), 32'(vecs[i].valid));
      chk($sformatf("v%0d_note", i), 32'(note), 32'(vecs[i].note));
      chk($sformatf("v%0d_idx", i), 32'(beat_idx), 32'(vecs[i].idx));
      chk($sformatf("v%0d_count", i), 32'(note_count), 32'(vecs[i].count));
      chk($sformatf("v%0d_addr", i), 32'(rom_addr), 32'(vecs[i].addr));
      chk($sformatf("v%0d_playing", i), 32'(playing), 32'(vecs[i].playing));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].done));
    end

    // Pause 3 cycles mid-beat, then pause held across the beat-2 tick.
    for (int k = 1; k <= 18; k++) begin
      p = (k >= 6 && k <= 8) || (k >= 15 && k <= 17);
      step(1, 0, p, 0);
      chk($sformatf("pause_valid_k%0d", k), 32'(note_valid), 32'(k == 4 || k == 11 || k == 18));
      chk($sformatf("pause_playing_k%0d", k), 32'(playing), 32'd1);
      if (k == 11) begin
        chk("pause_note_b1", 32'(note), 32'h00);
        chk("pause_idx_b1", 32'(beat_idx), 32'd1);
      end
      if (k == 18) begin
        chk("pause_note_b2", 32'(note), 32'h04);
        chk("pause_idx_b2", 32'(beat_idx), 32'd2);
      end
    end

    // Stop coincident with the beat-3 tick.
    for (int k = 19; k <= 21; k++) begin
      step(1, 0, 0, 0);
      chk("pre_stop_valid", 32'(note_valid), 32'd0);
    end
    step(1, 0, 0, 1);
    chk("stop_valid", 32'(note_valid), 32'd0);
    chk("stop_playing", 32'(playing), 32'd0);
    chk("stop_done", 32'(done), 32'd0);
    chk("stop_addr", 32'(rom_addr), 32'd0);
    chk("stop_idx_hold", 32'(beat_idx), 32'd2);
    chk("stop_note_hold", 32'(note), 32'h04);
    chk("stop_count_hold", 32'(note_count), 32'd2);
    step(1, 0, 0, 0);
    chk("idle_valid", 32'(note_valid), 32'd0);

    // Replay from index 0; a start while playing is ignored.
    step(1, 1, 0, 0);
    chk("replay_count", 32'(note_count), 32'd0);
    chk("replay_playing", 32'(playing), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      step(1, k == 2, 0, 0);
      chk($sformatf("ign_start_valid_k%0d", k), 32'(note_valid), 32'(k == 4));
    end
    chk("replay_idx", 32'(beat_idx), 32'd0);
    chk("replay_note", 32'(note), 32'h01);
    chk("replay_count1", 32'(note_count), 32'd1);

    // start and stop together in IDLE.
    step(1, 0, 0, 1);
    chk("e_stop_playing", 32'(playing), 32'd0);
    step(1, 1, 0, 1);
    chk("ss_playing", 32'(playing), 32'd0);
    chk("ss_done", 32'(done), 32'd0);
    chk("ss_addr", 32'(rom_addr), 32'd0);
    for (int k = 0; k < 6; k++) begin
      step(1, 0, 0, 0);
      chk("ss_idle_valid", 32'(note_valid), 32'd0);
      chk("ss_idle_playing", 32'(playing), 32'd0);
    end

    // Reset mid-song after beat 2.
    step(1, 1, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      step(1, 0, 0, 0);
      chk($sformatf("rst_run_valid_k%0d", k), 32'(note_valid), 32'(k % 4 == 0));
    end
    chk("rst_run_idx", 32'(beat_idx), 32'd2);
    step(0, 0, 0, 0);
    chk("rst_valid", 32'(note_valid), 32'd0);
    chk("rst_note", 32'(note), 32'd0);
    chk("rst_idx", 32'(beat_idx), 32'd0);
    chk("rst_count", 32'(note_count), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_playing", 32'(playing), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    for (int k = 0; k < 8; k++) begin
      step(1, 0, 0, 0);
      chk("post_rst_valid", 32'(note_valid), 32'd0);
      chk("post_rst_playing", 32'(playing), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
# song_sequencer

Beat-rate controller that walks the 128-entry song note ROM (7-bit address in, registered 5-bit lane mask out, one-cycle read latency) and issues one note per beat to the downstream lane/scroll logic. Owns start/pause/stop sequencing, the beat divider, end-of-song detection and a count of non-empty notes for scoring. Sits between the game-control FSM (start/pause/stop) and the note-highway renderer.

## Interface
- BEAT_DIV, 12_500_000: clock cycles per beat; legal range 2..2^24-1.
- SONG_LEN, 94: number of ROM entries played, indices 0..SONG_LEN-1; legal range 1..128.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to begin the song from index 0.
- pause  in  1  level; while high, playback is frozen.
- stop  in  1  one-cycle request to abort and return to idle.
- rom_addr  out  7  note ROM address.
- rom_data  in  5  note ROM registered output; bit i = lane i.
- note  out  5  lane mask of the note being issued.
- note_valid  out  1  one-cycle strobe qualifying note.
- beat_idx  out  7  index of the note most recently issued.
- note_count  out  7  number of issued notes with nonzero mask, saturating at 127.
- playing  out  1  high in PLAYING and PAUSED.
- done  out  1  high in DONE.

## Operation
- States: IDLE, PLAYING, PAUSED, DONE. Reset → IDLE.
- Reset values: rom_addr 0, note 0, note_valid 0, beat_idx 0, note_count 0, playing 0, done 0, divider 0.
- Priority, evaluated each cycle: rst_n low, then stop, then start, then pause, then beat tick.
- stop in any state → IDLE. rom_addr, divider and note_valid clear. note, beat_idx and note_count hold.
- start in IDLE or DONE → PLAYING. rom_addr, divider and note_count clear; done drops.
- start in PLAYING or PAUSED is ignored.
- PLAYING with pause high → PAUSED. PAUSED with pause low → PLAYING. Divider and rom_addr hold in PAUSED; no tick fires.
- Divider counts 0..BEAT_DIV-1 only in PLAYING with pause low. A tick is the cycle in which the divider equals BEAT_DIV-1; the divider wraps to 0 on that edge.
- On a tick edge:
  - note <= rom_data; beat_idx <= rom_addr; note_valid <= 1.
  - note_count increments if rom_data != 0, saturating at 127.
  - If rom_addr == SONG_LEN-1: state → DONE and rom_addr <= 0.
  - Otherwise rom_addr <= rom_addr + 1.
- note_valid is high for exactly one cycle per tick, otherwise 0.
- Zero masks (rests) are issued normally with note_valid = 1.
- DONE holds until start or stop. No ticks fire in DONE.
- Arithmetic: rom_addr is 7-bit and never exceeds SONG_LEN-1. The divider is 24-bit. SONG_LEN = 128 ends at index 127 without wrap ambiguity.

## Timing
- rom_addr is stable for at least BEAT_DIV ≥ 2 cycles before each tick, so the ROM's one-cycle latency is always satisfied; no fetch handshake is needed.
- Start at edge E0: the first note_valid is high in the cycle after edge E0+BEAT_DIV, carrying ROM[0].
- Issue interval: exactly BEAT_DIV cycles while unpaused.
- Pause of P cycles stretches the current beat by exactly P cycles; the residual divider count is preserved.
- Pause high in the would-be tick cycle suppresses that tick; it fires on the first unpaused cycle.
- done and playing are registered and change on the same edge as the state.
- The last note_valid (index SONG_LEN-1) and done rise on the same edge.
- stop and tick in the same cycle: stop wins, no note_valid.
- start and stop in the same cycle: stop wins.
- rst_n low mid-song: all outputs take reset values on that edge.

## Test plan
Bench parameters: BEAT_DIV = 4, SONG_LEN = 6; behavioural ROM with one-cycle latency loaded with 01,00,04,10,08,02.
- Reset, then start at cycle 0 → note_valid at cycles 5, 9, 13, 17, 21, 25.
  - Notes issued: 01,00,04,10,08,02; beat_idx 0..5.
  - done rises with the final note; note_count = 5; rom_addr = 0.
- Pause high for 3 cycles starting 2 cycles after the first note → second note_valid delayed by 3 cycles (cycle 12); subsequent spacing stays 4; playing stays 1.
- Pause held through the tick cycle of beat 2 → no note_valid while pause is high; the tick fires on the first cycle after pause falls, carrying index 2.
- stop in the same cycle as the beat-3 tick → no note_valid; state IDLE; rom_addr 0. A following start replays from index 0 with note_count reset to 0.
- start and stop together in IDLE → remains IDLE. start while PLAYING → ignored, beat sequence unchanged. start in DONE → replays; done falls on that edge.
- rst_n low for one cycle mid-song (after beat 2) → all outputs at reset values next cycle; no further note_valid until start.
